// File: rtl/inv_sub_bytes.sv
// AES inverse SubBytes stage: each of the 16 state bytes goes through the FIPS-197
// inverse S-box, and the result is registered with a one-cycle valid strobe.
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] bloco,
    output logic         out_valid,
    output logic [127:0] saida
);

    // Byte lookup table: the entry at index x is InvSbox(x).
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [127:0] w_sub;
    logic [127:0] r_saida;
    logic         r_valid;

    // Lanes are fully independent: each byte indexes its own copy of the table.
    always_comb begin
        w_sub = '0;
        for (int k = 0; k < 16; k++) begin
            w_sub[8*k +: 8] = INV_SBOX[bloco[8*k +: 8]];
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_saida <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_saida <= w_sub;
            end
        end
    end

    assign saida     = r_saida;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Self-checking bench for inv_sub_bytes; the reference InvSbox is derived from GF(2^8)
// arithmetic (forward S-box = inverse + affine map, then inverted), not from a table.
module tb_inv_sub_bytes;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] bloco;
    logic         out_valid;
    logic [127:0] saida;

    int errors = 0;
    int checks = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    inv_sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .bloco     (bloco),
        .out_valid (out_valid),
        .saida     (saida)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_inv(input logic [127:0] x);
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[x[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] x);
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = fwd_tab[x[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] x;
    logic [127:0] last;
    logic [127:0] exp_q [$];

    initial begin
        for (int v = 0; v < 256; v++) fwd_tab[v] = fwd_sbox(8'(v));
        for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);

        rst = 1'b1; in_valid = 1'b0; bloco = '0;
        #1;
        tick(); tick();
        check("reset_saida", saida, '0);
        check("reset_valid", {127'b0, out_valid}, 128'd1 - 128'd1);

        // Reset beats in_valid.
        in_valid = 1'b1; bloco = rand128();
        tick();
        check("rst_prio_saida", saida, '0);
        check("rst_prio_valid", {127'b0, out_valid}, '0);

        // First input after reset: known vector.
        rst = 1'b0;
        bloco = 128'h50414c41565241544553544543494652;
        tick();
        check("vec_saida", saida, 128'h6cf85df8b948f8fd6850fd6864a49848);
        check("vec_valid", {127'b0, out_valid}, 128'd1);

        bloco = 128'h0001414c50637cff0001414c50637cff;
        tick();
        check("anchors", saida, 128'h5209f85d6c00017d5209f85d6c00017d);

        bloco = '0;
        tick();
        check("all_zero", saida, {16{8'h52}});
        bloco = '1;
        tick();
        check("all_ff", saida, {16{8'h7d}});

        // Every byte value through every lane, back to back.
        for (int v = 0; v < 256; v++) begin
            for (int k = 0; k < 16; k++) bloco[8*k +: 8] = 8'(v + 17 * k);
            x = bloco;
            tick();
            check("sweep", saida, model_inv(x));
            check("sweep_valid", {127'b0, out_valid}, 128'd1);
        end

        // Three back-to-back random states, then a bubble.
        for (int i = 0; i < 3; i++) begin
            bloco = rand128();
            exp_q.push_back(model_inv(bloco));
            tick();
            last = exp_q.pop_front();
            check("b2b_saida", saida, last);
            check("b2b_valid", {127'b0, out_valid}, 128'd1);
        end
        in_valid = 1'b0; bloco = rand128();
        tick();
        check("hold_valid", {127'b0, out_valid}, '0);
        check("hold_saida", saida, last);
        tick();
        check("hold_saida2", saida, last);

        // Round trip: forward S-box applied by the bench, inverse by the DUT.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = rand128();
            bloco = model_fwd(x);
            tick();
            check("round_trip", saida, x);
        end

        // Reset lands on the edge that would have captured a new input.
        x = rand128();
        bloco = model_fwd(x);
        rst = 1'b1;
        tick();
        check("mid_rst_saida", saida, '0);
        check("mid_rst_valid", {127'b0, out_valid}, '0);

        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("post_rst_idle", {127'b0, out_valid}, '0);
        in_valid = 1'b1;
        tick();
        check("post_rst_valid", {127'b0, out_valid}, 128'd1);
        check("post_rst_saida", saida, x);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
